dffram_ahbl_ctrl: RTL and testbench
===================================

// Module: dffram_ahbl_ctrl
// PURPOSE
//   Parametrised AHB-Lite slave controller for a single-port DFFRAM macro (any power-of-2 depth x 32).
//   Supersedes the fixed 128/256/512 wrappers and adds byte/halfword writes, single-port
//   write/read collision stalls and two-cycle ERROR responses. Sits between the bus and the macro.
// PARAMETERS
//   DEPTH       256  words in attached macro; power of 2, 32..4096; AW = $clog2(DEPTH)
//   ADDR_WIDTH  16   decoded HADDR window bits; HADDR[ADDR_WIDTH-1:AW+2] != 0 is out-of-range
//   ERR_EN      1    1: out-of-range/misaligned/HSIZE>2 transfers get ERROR; 0: treated as normal, index wraps
// PORTS
//   HCLK       in   1   bus clock
//   HRESET     in   1   synchronous, active-high reset
//   HSEL       in   1   slave select
//   HADDR      in   32  address (only [ADDR_WIDTH-1:0] decoded)
//   HTRANS     in   2   transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a transfer
//   HWRITE     in   1   1 write, 0 read
//   HSIZE      in   3   0 byte, 1 halfword, 2 word
//   HREADY     in   1   bus ready (address phase qualifier)
//   HWDATA     in   32  write data (data phase)
//   HRDATA     out  32  read data
//   HREADYOUT  out  1   slave ready
//   HRESP      out  1   0 OKAY, 1 ERROR
//   RAM_EN     out  1   macro enable
//   RAM_WE     out  4   macro byte write enables
//   RAM_A      out  AW  macro word address
//   RAM_DI     out  32  macro write data
//   RAM_DO     in   32  macro read data, valid the cycle after a read-enabled edge
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Accept = HSEL & HREADY & HTRANS[1]; word = HADDR[AW+1:2].
//   Lanes: HSIZE0 -> 4'b0001<<HADDR[1:0]; HSIZE1 -> 4'b0011<<{HADDR[1],1'b0}; HSIZE2 -> 4'b1111.
//   Error (ERR_EN=1): out-of-range, HSIZE1 with HADDR[0]=1, HSIZE2 with HADDR[1:0]!=0, HSIZE>2.
//   FSM: IDLE, WR_DP, RD_DP, RD_STALL, ERR1, ERR2.
//   Read accepted from IDLE/RD_DP/ERR2: RAM_EN=1, RAM_WE=0, RAM_A=word same cycle (comb) -> RD_DP;
//     RD_DP: HREADYOUT=1, HRDATA=RAM_DO (zero wait).
//   Write accepted: addr/lanes registered -> WR_DP; WR_DP: RAM_EN=1, RAM_WE=lanes, RAM_A=reg addr,
//     RAM_DI=HWDATA, HREADYOUT=1 (zero wait). Write-after-write back-to-back at full rate.
//   Collision: read accepted while in WR_DP (port busy): read addr registered -> RD_STALL;
//     RD_STALL: HREADYOUT=0, RAM read issued from reg addr -> RD_DP (exactly 1 wait state).
//   Error accepted: no RAM access -> ERR1 (HREADYOUT=0,HRESP=1) -> ERR2 (HREADYOUT=1,HRESP=1).
//   New transfer accepted in ERR2/RD_DP/WR_DP handled as above; no accept -> IDLE.
//   HRDATA outside RD_DP = hold register (last completed read data); reset 0.
//   IDLE/idle/busy transfers or HSEL=0: HREADYOUT=1, HRESP=0, RAM_EN=0.
//   RAM_EN=0 whenever HRESET=1; a read and a write never drive the port in the same cycle.
//   Reset (any state, incl. mid-stall/error): next cycle IDLE, HREADYOUT=1, HRESP=0, RAM_EN=0,
//     RAM_WE=0, HRDATA=0; pending write/stalled read discarded.
// TESTING
//   Word write 0x0000_0010<-0xDEADBEEF then read -> 1 wait state, HRDATA=0xDEADBEEF, HRESP=0.
//   Byte writes 0xAA@0x21, halfword 0x5566@0x22 over 0x11223344@0x20 -> read 0x5566AA44.
//   Read, read, write, write back-to-back -> HREADYOUT=1 throughout, RAM_EN each data cycle.
//   DEPTH=256: read HADDR=0x0400, halfword HADDR=0x3 -> HRESP=1 two cycles, HREADYOUT 0 then 1, RAM_EN=0.
//   ERR_EN=0 same 0x0400 write -> lands at word 0, no error.
//   Assert HRESET during RD_STALL -> next cycle HREADYOUT=1, HRDATA=0, RAM_EN=0, stalled read dropped.

Source files
------------

// File: rtl/dffram_ahbl_ctrl_if.sv
// dffram_ahbl_ctrl_if: AHB-Lite bus bundle between a bus master and the DFFRAM controller
interface dffram_ahbl_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/dffram_ahbl_ctrl.sv
// dffram_ahbl_ctrl: AHB-Lite slave for a single-port DFFRAM with sub-word writes, collision stalls and ERROR responses
module dffram_ahbl_ctrl #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter bit ERR_EN     = 1'b1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 HCLK_i,
    input  logic                 HRESET_i,
    dffram_ahbl_ctrl_if.slave    bus,
    output logic                 RAM_EN_o,
    output logic [3:0]           RAM_WE_o,
    output logic [AW-1:0]        RAM_A_o,
    output logic [31:0]          RAM_DI_o,
    input  logic [31:0]          RAM_DO_i
);
    typedef enum logic [2:0] {IDLE, WR_DP, RD_DP, RD_STALL, ERR1, ERR2} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    lanes_q, lanes_d;
    logic [31:0]   hold_q;
    logic          hreadyout_q, hresp_q;
    logic          take, oor, bad, err, rd_now, port_busy;
    logic [AW-1:0] word;
    logic [3:0]    lanes;
    logic          unused_bits;

    assign unused_bits = &{1'b0, bus.HADDR[31:ADDR_WIDTH], bus.HTRANS[0]};
    assign take  = bus.HSEL & bus.HREADY & bus.HTRANS[1] & (state_q != RD_STALL) & (state_q != ERR1);
    assign word  = bus.HADDR[AW+1:2];
    assign oor   = (bus.HADDR[ADDR_WIDTH-1:0] >> (AW + 2)) != '0;
    assign bad   = oor | ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                   ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'd0)) | (bus.HSIZE > 3'd2);
    assign err   = ERR_EN & bad;
    assign lanes = bus.HSIZE == 3'd0 ? 4'b0001 << bus.HADDR[1:0] :
                   bus.HSIZE == 3'd1 ? 4'b0011 << {bus.HADDR[1], 1'b0} : 4'b1111;
    // The write data phase owns the port, so a read arriving then is deferred one cycle
    assign port_busy = state_q == WR_DP;
    assign rd_now    = take & ~err & ~bus.HWRITE & ~port_busy;

    always_comb begin
        state_d = IDLE;
        addr_d  = addr_q;
        lanes_d = lanes_q;
        if (state_q == RD_STALL) state_d = RD_DP;
        else if (state_q == ERR1) state_d = ERR2;
        else if (take) begin
            if (err) state_d = ERR1;
            else if (bus.HWRITE) begin
                state_d = WR_DP;
                addr_d  = word;
                lanes_d = lanes;
            end
            else if (port_busy) begin
                state_d = RD_STALL;
                addr_d  = word;
            end
            else state_d = RD_DP;
        end
    end

    always_ff @(posedge HCLK_i) begin
        if (HRESET_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lanes_q     <= '0;
            hold_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lanes_q     <= lanes_d;
            hreadyout_q <= !(state_d == RD_STALL || state_d == ERR1);
            hresp_q     <= state_d == ERR1 || state_d == ERR2;
            if (state_q == RD_DP) hold_q <= RAM_DO_i;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = state_q == RD_DP ? RAM_DO_i : hold_q;
    assign RAM_EN_o      = ~HRESET_i & (port_busy | (state_q == RD_STALL) | rd_now);
    assign RAM_WE_o      = (~HRESET_i & port_busy) ? lanes_q : 4'b0000;
    assign RAM_A_o       = (port_busy | (state_q == RD_STALL)) ? addr_q : word;
    assign RAM_DI_o      = bus.HWDATA;
endmodule

// File: tb/tb_dffram_ahbl_ctrl.sv
// tb_dffram_ahbl_ctrl: pipelined AHB-Lite master with random traffic checked against a word-array reference model
module tb_dffram_ahbl_ctrl;
    localparam int DEPTH = 256;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dffram_ahbl_ctrl_if bus ();
    dffram_ahbl_ctrl_if bus0 ();
    assign bus.HREADY  = bus.HREADYOUT;
    assign bus0.HREADY = bus0.HREADYOUT;

    logic        ram_en, ram_en0;
    logic [3:0]  ram_we, ram_we0;
    logic [7:0]  ram_a, ram_a0;
    logic [31:0] ram_di, ram_do, ram_di0, ram_do0;
    logic [31:0] mem [DEPTH];
    logic [31:0] mem0 [DEPTH];
    logic [31:0] refm [DEPTH];

    dffram_ahbl_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(16), .ERR_EN(1'b1)) u_dut (
        .HCLK_i(clk), .HRESET_i(rst), .bus(bus), .RAM_EN_o(ram_en), .RAM_WE_o(ram_we),
        .RAM_A_o(ram_a), .RAM_DI_o(ram_di), .RAM_DO_i(ram_do));
    dffram_ahbl_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(16), .ERR_EN(1'b0)) u_dut0 (
        .HCLK_i(clk), .HRESET_i(rst), .bus(bus0), .RAM_EN_o(ram_en0), .RAM_WE_o(ram_we0),
        .RAM_A_o(ram_a0), .RAM_DI_o(ram_di0), .RAM_DO_i(ram_do0));

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end
        if (ram_en0) begin
            for (int b = 0; b < 4; b++) if (ram_we0[b]) mem0[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
            ram_do0 <= mem0[ram_a0];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic        dp_v = 1'b0, dp_wr = 1'b0, dp_err = 1'b0;
    logic [31:0] dp_addr = '0, dp_wdata = '0;
    logic [2:0]  dp_size = '0;
    int          dp_exp_w = 0, dp_w = 0;
    logic        r_sel, r_wr;
    logic [1:0]  r_tr;
    logic [2:0]  r_s;
    logic [31:0] r_a, r_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
        return a[15:0] >= 16'h0400 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0) || s > 3'd2;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] a, input logic [2:0] s);
        if (s == 3'd0) return 32'h0000_00FF << (8 * a[1:0]);
        if (s == 3'd1) return 32'h0000_FFFF << (16 * a[1]);
        return 32'hFFFF_FFFF;
    endfunction

    // Present one address phase until accepted, finishing the previous transfer's data phase meanwhile
    task automatic issue(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        logic done, xfer, e;
        logic [31:0] m;
        xfer = sel && tr[1];
        e = is_err(a, s);
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = wr; bus.HADDR = a; bus.HSIZE = s;
            bus.HWDATA = dp_wdata;
            #1;
            if (!bus.HREADYOUT && dp_w < 4) begin
                check("wait_resp", 32'(bus.HRESP), 32'(dp_v && dp_err));
                if (dp_err) check("err_ram_en", 32'(ram_en), 32'd0);
                dp_w++;
            end else done = 1'b1;
        end
        check("ready", 32'(bus.HREADYOUT), 32'd1);
        check("resp", 32'(bus.HRESP), 32'(dp_v && dp_err));
        if (dp_v) begin
            check("waits", 32'(dp_w), 32'(dp_exp_w));
            m = lane_mask(dp_addr, dp_size);
            if (!dp_err && dp_wr) begin
                check("wr_en", 32'(ram_en), 32'd1);
                check("wr_we", 32'(ram_we), 32'({m[24], m[16], m[8], m[0]}));
                check("wr_a", 32'(ram_a), 32'(dp_addr[9:2]));
                refm[dp_addr[9:2]] = (refm[dp_addr[9:2]] & ~m) | (dp_wdata & m);
            end
            if (!dp_err && !dp_wr) check("rdata", bus.HRDATA, refm[dp_addr[9:2]]);
        end
        if (xfer && !e && !wr && !(dp_v && dp_wr && !dp_err)) begin
            check("rd_en", 32'(ram_en), 32'd1);
            check("rd_we", 32'(ram_we), 32'd0);
            check("rd_a", 32'(ram_a), 32'(a[9:2]));
        end
        dp_exp_w = !xfer ? 0 : e ? 1 : (!wr && dp_v && dp_wr && !dp_err) ? 1 : 0;
        dp_v = xfer; dp_wr = wr; dp_err = e; dp_addr = a; dp_size = s; dp_wdata = wd; dp_w = 0;
    endtask

    task automatic idle();
        issue(1'b0, 2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            refm[i] = mem[i];
            mem0[i] = '0;
        end
        bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HADDR = 0; bus.HSIZE = 0; bus.HWDATA = 0;
        bus0.HSEL = 0; bus0.HTRANS = 0; bus0.HWRITE = 0; bus0.HADDR = 0; bus0.HSIZE = 0; bus0.HWDATA = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.HREADYOUT), 32'd1);
        check("rst_resp", 32'(bus.HRESP), 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_rdata", bus.HRDATA, 32'd0);
        rst = 1'b0;
        // word write then colliding read
        issue(1, 2'd2, 1, 32'h0000_0010, 3'd2, 32'hDEADBEEF);
        issue(1, 2'd2, 0, 32'h0000_0010, 3'd2, 32'h0);
        idle();
        check("deadbeef", bus.HRDATA, 32'hDEADBEEF);
        // sub-word merge
        issue(1, 2'd2, 1, 32'h20, 3'd2, 32'h11223344);
        issue(1, 2'd3, 1, 32'h21, 3'd0, {4{8'hAA}});
        issue(1, 2'd3, 1, 32'h22, 3'd1, {2{16'h5566}});
        issue(1, 2'd2, 0, 32'h20, 3'd2, 32'h0);
        idle();
        check("subword", bus.HRDATA, 32'h5566AA44);
        // back-to-back read, read, write, write
        issue(1, 2'd2, 0, 32'h10, 3'd2, 32'h0);
        issue(1, 2'd3, 0, 32'h20, 3'd2, 32'h0);
        issue(1, 2'd3, 1, 32'h30, 3'd2, 32'h0102_0304);
        issue(1, 2'd3, 1, 32'h34, 3'd2, 32'h0506_0708);
        idle();
        // out-of-range read, misaligned halfword write
        issue(1, 2'd2, 0, 32'h0000_0400, 3'd2, 32'h0);
        idle();
        issue(1, 2'd2, 1, 32'h0000_0003, 3'd1, 32'hFFFF_FFFF);
        idle();
        idle();
        // reset while a read is stalled behind a write
        issue(1, 2'd2, 1, 32'h40, 3'd2, 32'hCAFEF00D);
        issue(1, 2'd2, 0, 32'h40, 3'd2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.HSEL = 0; bus.HTRANS = 0;
        #1;
        check("stall_ready", 32'(bus.HREADYOUT), 32'd0);
        check("stall_rst_en", 32'(ram_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.HREADYOUT), 32'd1);
        check("post_rst_rdata", bus.HRDATA, 32'd0);
        check("post_rst_en", 32'(ram_en), 32'd0);
        check("post_rst_resp", 32'(bus.HRESP), 32'd0);
        dp_v = 1'b0;
        dp_w = 0;
        // random traffic
        for (int i = 0; i < 600; i++) begin
            r_sel = $urandom_range(0, 9) != 0;
            r_tr  = $urandom_range(0, 5) < 4 ? {1'b1, 1'($urandom)} : 2'($urandom);
            r_wr  = 1'($urandom);
            r_s   = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_a   = {16'($urandom), 6'd0, 4'($urandom), 2'($urandom), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) r_a[15:0] = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (r_s == 3'd1) r_a[0] = 1'b0;
                if (r_s == 3'd2) r_a[1:0] = 2'd0;
            end
            r_wd = $urandom;
            issue(r_sel, r_tr, r_wr, r_a, r_s, r_wd);
        end
        idle();
        idle();
        // no-error variant: out-of-range index wraps
        @(negedge clk);
        bus0.HSEL = 1; bus0.HTRANS = 2'd2; bus0.HWRITE = 1; bus0.HADDR = 32'h0000_0400; bus0.HSIZE = 3'd2;
        @(negedge clk);
        bus0.HSEL = 0; bus0.HTRANS = 2'd0; bus0.HWDATA = 32'h0BADC0DE;
        #1;
        check("ne_ready", 32'(bus0.HREADYOUT), 32'd1);
        check("ne_resp", 32'(bus0.HRESP), 32'd0);
        check("ne_en", 32'(ram_en0), 32'd1);
        check("ne_a", 32'(ram_a0), 32'd0);
        @(negedge clk);
        bus0.HSEL = 1; bus0.HTRANS = 2'd2; bus0.HWRITE = 0; bus0.HADDR = 32'h0; bus0.HSIZE = 3'd2;
        @(negedge clk);
        bus0.HSEL = 0; bus0.HTRANS = 2'd0;
        #1;
        check("ne_rdata", bus0.HRDATA, 32'h0BADC0DE);
        check("ne_rd_resp", 32'(bus0.HRESP), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
